// File: rtl/pc_ctrl.sv
// ---------------------------------------------------------------------------
// pc_ctrl -- program counter sequencer for a small instruction ROM.
//
// Once started, the block walks the ROM address from 0. Each RUN cycle it
// either holds (stall), finishes (halt), jumps (branch_en) or steps by one.
// Stepping past the last ROM address does not wrap. It stops in DONE with a
// sticky overrun flag and keeps the last address on pc.
//
// Parameters
//   PC_W   program counter width (ROM depth 2^PC_W)
//   CNT_W  cycle counter width
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-high
//   start        one-cycle request to run from address 0 (IDLE/DONE only)
//   stall        hold pc and state this cycle
//   halt         decode saw a halt opcode at the current pc
//   branch_en    taken branch request
//   branch_tgt   absolute branch target
//   pc           registered ROM address
//   fetch_valid  pc is a live instruction address (RUN)
//   done         program finished, held until the next start
//   overrun      sticky, pc ran off the end of the ROM without a halt
//   cycle_cnt    cycles spent in RUN, saturating
//
// Build option
//   PC_CYCLE_CNT_EN  when defined, cycle_cnt counts every RUN cycle
//                    (stalled cycles included) and saturates at all-ones.
//                    When undefined, no counter is built and cycle_cnt is 0.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | out of reset, waiting for start
// RUN   | fetching: pc is a live address, fetch_valid=1
// DONE  | halted or overran, pc/overrun/cycle_cnt frozen, done=1
// ---------------------------------------------------------------------------
module pc_ctrl #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             halt,
    input  logic             branch_en,
    input  logic [PC_W-1:0]  branch_tgt,
    output logic [PC_W-1:0]  pc,
    output logic             fetch_valid,
    output logic             done,
    output logic             overrun,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] PC_LAST = '1;

    state_t state;

    // Outputs are registered next to the state so fetch_valid and done
    // change on the same edge as the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            fetch_valid <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_RUN;
                        pc          <= '0;
                        fetch_valid <= 1'b1;
                        done        <= 1'b0;
                        overrun     <= 1'b0;
                    end
                end
                S_RUN: begin
                    // A stall freezes everything, so halt and branch wait
                    // until decode presents them again on an unstalled cycle.
                    if (!stall) begin
                        if (halt) begin
                            state       <= S_DONE;
                            fetch_valid <= 1'b0;
                            done        <= 1'b1;
                        end else if (branch_en) begin
                            pc <= branch_tgt;
                        end else if (pc == PC_LAST) begin
                            // Running off the end: keep the last address
                            // visible for debug rather than wrapping to 0.
                            state       <= S_DONE;
                            fetch_valid <= 1'b0;
                            done        <= 1'b1;
                            overrun     <= 1'b1;
                        end else begin
                            pc <= pc + PC_W'(1);
                        end
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    pc          <= '0;
                    fetch_valid <= 1'b0;
                    done        <= 1'b0;
                    overrun     <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_CYCLE_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Counts on the edge that ends each RUN cycle, so the halt cycle and
    // stalled cycles are all included. It clears on the start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else if (state != S_RUN) begin
            if (start) begin
                cycle_cnt <= '0;
            end
        end else if (cycle_cnt != CNT_MAX) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end
`else
    assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
module tb_pc_ctrl;

    localparam int PC_W  = 10;
    localparam int CNT_W = 4;   // narrow so saturation is reachable quickly
    localparam logic [PC_W-1:0]  PC_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             stall = 1'b0;
    logic             halt = 1'b0;
    logic             branch_en = 1'b0;
    logic [PC_W-1:0]  branch_tgt = '0;
    logic [PC_W-1:0]  pc;
    logic             fetch_valid;
    logic             done;
    logic             overrun;
    logic [CNT_W-1:0] cycle_cnt;

    pc_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stall      (stall),
        .halt       (halt),
        .branch_en  (branch_en),
        .branch_tgt (branch_tgt),
        .pc         (pc),
        .fetch_valid(fetch_valid),
        .done       (done),
        .overrun    (overrun),
        .cycle_cnt  (cycle_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PC_W-1:0]  pc;
        logic             fv;
        logic             dn;
        logic             ov;
        logic [CNT_W-1:0] cnt;
        string            tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // reference model: 0 idle, 1 run, 2 done
    int               m_st = 0;
    logic [PC_W-1:0]  m_pc = '0;
    logic             m_ov = 1'b0;
    logic [CNT_W-1:0] m_cnt = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, predict the post-edge outputs into the
    // scoreboard, then pop and compare once the edge has passed.
    task automatic cyc(input string tag, input logic r, input logic s, input logic st,
                       input logic h, input logic b, input logic [PC_W-1:0] t);
        exp_t e;
        exp_t got;
        reset = r; start = s; stall = st; halt = h; branch_en = b; branch_tgt = t;
        if (r) begin
            m_st = 0; m_pc = '0; m_ov = 1'b0; m_cnt = '0;
        end else if (m_st != 1) begin
            if (s) begin
                m_st = 1; m_pc = '0; m_ov = 1'b0; m_cnt = '0;
            end
        end else begin
`ifdef PC_CYCLE_CNT_EN
            if (m_cnt != CNT_MAX) m_cnt = m_cnt + CNT_W'(1);
`endif
            if (!st) begin
                if (h) m_st = 2;
                else if (b) m_pc = t;
                else if (m_pc == PC_MAX) begin
                    m_st = 2; m_ov = 1'b1;
                end else m_pc = m_pc + PC_W'(1);
            end
        end
        e.pc = m_pc; e.fv = (m_st == 1); e.dn = (m_st == 2); e.ov = m_ov;
        e.cnt = m_cnt; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({got.tag, "_pc"},  32'(pc),          32'(got.pc));
        chk({got.tag, "_fv"},  32'(fetch_valid), 32'(got.fv));
        chk({got.tag, "_dn"},  32'(done),        32'(got.dn));
        chk({got.tag, "_ov"},  32'(overrun),     32'(got.ov));
        chk({got.tag, "_cnt"}, 32'(cycle_cnt),   32'(got.cnt));
    endtask

    initial begin
        // reset wins over start
        cyc("rst0", 1, 1, 0, 0, 0, 10'h0);
        cyc("rst1", 1, 1, 1, 1, 1, 10'h3);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_fv", 32'(fetch_valid), 32'd0);
        chk("rst_cnt", 32'(cycle_cnt), 32'd0);

        // stall/halt/branch ignored in IDLE
        cyc("idle_ign", 0, 0, 1, 1, 1, 10'h55);
        chk("idle_pc", 32'(pc), 32'd0);

        // start, count to 5, halt at 5
        cyc("start_a", 0, 1, 0, 0, 0, 10'h0);
        chk("start_a_fv", 32'(fetch_valid), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            cyc("inc_a", 0, 0, 0, 0, 0, 10'h0);
            chk("inc_a_seq", 32'(pc), 32'(i));
        end
        cyc("halt5", 0, 0, 0, 1, 0, 10'h0);
        chk("halt5_done", 32'(done), 32'd1);
        chk("halt5_pc", 32'(pc), 32'd5);
`ifdef PC_CYCLE_CNT_EN
        chk("halt5_cnt", 32'(cycle_cnt), 32'd6);
`else
        chk("halt5_cnt", 32'(cycle_cnt), 32'd0);
`endif
        cyc("done_ign0", 0, 0, 1, 1, 1, 10'h12);
        cyc("done_ign1", 0, 0, 0, 0, 1, 10'h13);
        chk("done_hold_pc", 32'(pc), 32'd5);

        // branch at pc=2 to 0x3F0, start ignored in RUN
        cyc("start_b", 0, 1, 0, 0, 0, 10'h0);
        cyc("inc_b1", 0, 0, 0, 0, 0, 10'h0);
        cyc("inc_b2", 0, 0, 0, 0, 0, 10'h0);
        cyc("br_3f0", 0, 0, 0, 0, 1, 10'h3F0);
        chk("br_3f0_pc", 32'(pc), 32'h3F0);
        cyc("inc_3f1", 0, 0, 0, 0, 0, 10'h0);
        chk("inc_3f1_pc", 32'(pc), 32'h3F1);
        cyc("start_ign", 0, 1, 0, 0, 0, 10'h0);
        chk("start_ign_pc", 32'(pc), 32'h3F2);

        // stall+halt for 3 cycles at pc=7, then a lone halt
        cyc("br_7", 0, 0, 0, 0, 1, 10'h7);
        for (int i = 0; i < 3; i++) begin
            cyc("stall_halt", 0, 0, 1, 1, 1, 10'h20);
            chk("stall_halt_pc", 32'(pc), 32'd7);
            chk("stall_halt_run", 32'(fetch_valid), 32'd1);
        end
        cyc("halt7", 0, 0, 0, 1, 0, 10'h0);
        chk("halt7_done", 32'(done), 32'd1);

        // branch taken from the last address, then overrun
        cyc("start_c", 0, 1, 0, 0, 0, 10'h0);
        cyc("br_3ff", 0, 0, 0, 0, 1, 10'h3FF);
        cyc("br_from_max", 0, 0, 0, 0, 1, 10'h4);
        chk("br_from_max_pc", 32'(pc), 32'd4);
        chk("br_from_max_ov", 32'(overrun), 32'd0);
        cyc("br_3ff_b", 0, 0, 0, 0, 1, 10'h3FF);
        cyc("stall_max", 0, 0, 1, 0, 1, 10'h1);
        cyc("overrun", 0, 0, 0, 0, 0, 10'h0);
        chk("overrun_flag", 32'(overrun), 32'd1);
        chk("overrun_pc", 32'(pc), 32'h3FF);
        chk("overrun_done", 32'(done), 32'd1);
        cyc("ovr_hold", 0, 0, 0, 0, 0, 10'h0);
        cyc("start_d", 0, 1, 0, 0, 0, 10'h0);
        chk("start_d_ov", 32'(overrun), 32'd0);
        chk("start_d_pc", 32'(pc), 32'd0);

        // long run to saturate the counter
        for (int i = 0; i < 20; i++) cyc("sat", 0, 0, 0, 0, 0, 10'h0);
`ifdef PC_CYCLE_CNT_EN
        chk("sat_cnt", 32'(cycle_cnt), 32'(CNT_MAX));
`else
        chk("sat_cnt", 32'(cycle_cnt), 32'd0);
`endif

        // reset mid-program at pc=9
        cyc("br_9", 0, 0, 0, 0, 1, 10'h9);
        chk("br_9_pc", 32'(pc), 32'd9);
        cyc("rst_run", 1, 1, 0, 1, 1, 10'h30);
        chk("rst_run_pc", 32'(pc), 32'd0);
        chk("rst_run_fv", 32'(fetch_valid), 32'd0);
        chk("rst_run_dn", 32'(done), 32'd0);
        cyc("rst_start", 1, 1, 0, 0, 0, 10'h0);
        chk("rst_start_fv", 32'(fetch_valid), 32'd0);
        cyc("post_rst", 0, 0, 0, 0, 0, 10'h0);
        chk("post_rst_fv", 32'(fetch_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
